pipe_pattern_checker: RTL

//  Parametrised multi-lane successor to the pipe-in pattern checker. Sits between okPipeIn (ep_read/ep_data/
//  ep_valid/ep_empty) and host wire endpoints.

---
 rtl/pipe_pattern_pkg.sv | 26 ++
 rtl/pipe_pattern_checker_if.sv | 14 +
 rtl/pipe_pattern_gen.sv | 67 ++++++
 rtl/pipe_pattern_checker.sv | 128 ++++++++++++
 4 files changed

// File: rtl/pipe_pattern_pkg.sv
// Shared types and helpers for the pipe pattern checker/generator family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_pattern_pkg;

  localparam int LANE_W = 32;
  localparam logic [LANE_W-1:0] THROTTLE_RESET = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MODE_COUNTER = 2'd0,
    MODE_LFSR    = 2'd1,
    MODE_WALK    = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // One LFSR step: shift left, new LSB is the XOR of taps 31, 21, 1 and 0.
  function automatic logic [LANE_W-1:0] lfsr_step(input logic [LANE_W-1:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

endpackage

// File: rtl/pipe_pattern_checker_if.sv
// Pipe FIFO read port bundle between a FIFO (master) and a pattern checker (slave).
// Latency: n/a (wires only).
// Backpressure: the slave paces the FIFO through pipe_in_read.
interface pipe_pattern_checker_if #(
  parameter int DATA_W = 64
);
  logic              pipe_in_read;
  logic [DATA_W-1:0] pipe_in_data;
  logic              pipe_in_valid;
  logic              pipe_in_empty;

  modport master (input pipe_in_read, output pipe_in_data, output pipe_in_valid, output pipe_in_empty);
  modport slave  (output pipe_in_read, input pipe_in_data, input pipe_in_valid, input pipe_in_empty);
endinterface

// File: rtl/pipe_pattern_gen.sv
// One lane's expected-pattern generator (counter / LFSR / walking-one).
// Latency: expected reflects init/advance one cycle after they are asserted.
// Backpressure: none; the owner decides when to advance.
module pipe_pattern_gen
  import pipe_pattern_pkg::*;
#(
  parameter int LANE_IDX = 0,
  parameter int LANES    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init,
  input  logic              advance,
  input  logic [1:0]        mode,
  input  logic [LANE_W-1:0] seed,
  output logic [LANE_W-1:0] expected
);

  localparam logic [LANE_W-1:0] LANE_OFS  = LANE_W'(LANE_IDX);
  localparam logic [LANE_W-1:0] LANE_STEP = LANE_W'(LANES);
  localparam int                WALK_SH   = LANE_IDX % LANE_W;
  localparam logic [LANE_W-1:0] WALK_INIT = 32'h1 << WALK_SH;

  mode_e             mode_q;
  logic [LANE_W-1:0] pat_q;
  logic [LANE_W-1:0] seed_ofs;
  logic [LANE_W-1:0] init_val;
  logic [LANE_W-1:0] next_val;

  assign seed_ofs = seed + LANE_OFS;

  // Starting value for beat 0 of this lane; an all-zero LFSR would lock up, so it becomes 1.
  always_comb begin
    init_val = seed_ofs;
    case (mode_e'(mode))
      MODE_LFSR: init_val = (seed_ofs == '0) ? 32'h1 : seed_ofs;
      MODE_WALK: init_val = WALK_INIT;
      default:   init_val = seed_ofs;
    endcase
  end

  // Value for the following beat; counter lanes interleave, so they step by the lane count.
  always_comb begin
    next_val = pat_q + LANE_STEP;
    case (mode_q)
      MODE_LFSR: next_val = lfsr_step(pat_q);
      MODE_WALK: next_val = {pat_q[LANE_W-2:0], pat_q[LANE_W-1]};
      default:   next_val = pat_q + LANE_STEP;
    endcase
  end

  // Pattern state: init (re)loads mode and seed state, advance steps one beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MODE_COUNTER;
      pat_q  <= '0;
    end else if (init) begin
      mode_q <= mode_e'(mode);
      pat_q  <= init_val;
    end else if (advance) begin
      pat_q  <= next_val;
    end
  end

  assign expected = pat_q;

endmodule

// File: rtl/pipe_pattern_checker.sv
// Multi-lane pipe-in pattern checker with saturating error count, beat count and sticky lane mask.
// Latency: counts/mask update 1 cycle after a valid beat; pipe_in_read is combinational from state.
// Backpressure: reads only in RUN, FIFO non-empty and throttle[0] set. Optional FIRST_ERR_CAPTURE_EN.
module pipe_pattern_checker
  import pipe_pattern_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [31:0]            seed,
  input  logic                   throttle_set,
  input  logic [31:0]            throttle_val,
  input  logic                   clear_errors,
  pipe_pattern_checker_if.slave  pin,
  output logic [CNT_W-1:0]       error_count,
  output logic [CNT_W-1:0]       beat_count,
  output logic [DATA_W/32-1:0]   lane_err_mask
`ifdef FIRST_ERR_CAPTURE_EN
  ,
  output logic                   first_err_valid,
  output logic [CNT_W-1:0]       first_err_beat,
  output logic [DATA_W-1:0]      first_err_exp,
  output logic [DATA_W-1:0]      first_err_act
`endif
);

  localparam int LANES = DATA_W / LANE_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q;
  logic [31:0]       throttle_q;
  logic              check_vld;
  logic [DATA_W-1:0] exp_dat;
  logic [LANES-1:0]  lane_mis;
  logic              beat_mis;

  // A beat arriving together with start belongs to the old run and is dropped.
  assign check_vld = (state_q == ST_RUN) & pin.pipe_in_valid & ~start;
  assign beat_mis  = |lane_mis;
  assign pin.pipe_in_read = (state_q == ST_RUN) & ~pin.pipe_in_empty & throttle_q[0];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    pipe_pattern_gen #(
      .LANE_IDX (gi),
      .LANES    (LANES)
    ) u_gen (
      .clk      (clk),
      .reset_n  (reset_n),
      .init     (start),
      .advance  (check_vld),
      .mode     (mode),
      .seed     (seed),
      .expected (exp_dat[gi*LANE_W +: LANE_W])
    );
    assign lane_mis[gi] = pin.pipe_in_data[gi*LANE_W +: LANE_W] != exp_dat[gi*LANE_W +: LANE_W];
  end

  // Run state: start enters (or restarts) RUN; only reset returns to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else if (start) begin
      state_q <= ST_RUN;
    end
  end

  // Read pacing mask: load has priority, otherwise rotate right each cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      throttle_q <= THROTTLE_RESET;
    end else if (throttle_set) begin
      throttle_q <= throttle_val;
    end else begin
      throttle_q <= {throttle_q[0], throttle_q[31:1]};
    end
  end

  // Beat count restarts on start and wraps; errors saturate and survive start; clear beats an update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_count    <= '0;
      error_count   <= '0;
      lane_err_mask <= '0;
    end else begin
      if (start) begin
        beat_count <= '0;
      end else if (check_vld) begin
        beat_count <= beat_count + CNT_ONE;
      end
      if (clear_errors) begin
        error_count   <= '0;
        lane_err_mask <= '0;
      end else if (check_vld && beat_mis) begin
        if (error_count != '1) begin
          error_count <= error_count + CNT_ONE;
        end
        lane_err_mask <= lane_err_mask | lane_mis;
      end
    end
  end

`ifdef FIRST_ERR_CAPTURE_EN
  // Capture the first failing beat since reset/clear; later failures leave it untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_err_valid <= 1'b0;
      first_err_beat  <= '0;
      first_err_exp   <= '0;
      first_err_act   <= '0;
    end else if (clear_errors) begin
      first_err_valid <= 1'b0;
      first_err_beat  <= '0;
      first_err_exp   <= '0;
      first_err_act   <= '0;
    end else if (check_vld && beat_mis && !first_err_valid) begin
      first_err_valid <= 1'b1;
      first_err_beat  <= beat_count;
      first_err_exp   <= exp_dat;
      first_err_act   <= pin.pipe_in_data;
    end
  end
`endif

endmodule
